// File: rtl/ecc_rd_err_handler.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_rd_err_handler
//  Description : Read-return stage behind the ECC decoder. Registers decoded
//                read data toward the host, flags uncorrectable words, keeps
//                saturating CE/UE counters and a first-error log, raises an
//                interrupt on UE and queues corrected words for scrub
//                write-back through a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_rd_err_handler #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SYND_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SCRUB_DEPTH = 4,
  parameter bit SCRUB_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  // decoder side
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_single_err,
  input  logic                  dec_double_err,
  input  logic [SYND_WIDTH-1:0] dec_syndrome,
  // host read-return side
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_uncorr,
  // scrub write-back side
  output logic                  scrub_valid,
  input  logic                  scrub_ready,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [DATA_WIDTH-1:0] scrub_data,
  output logic                  scrub_ovf,
  // statistics and error log
  output logic [CNT_WIDTH-1:0]  ce_count,
  output logic [CNT_WIDTH-1:0]  ue_count,
  output logic                  log_valid,
  output logic                  log_is_ue,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [SYND_WIDTH-1:0] log_syndrome,
  output logic                  irq,
  input  logic                  clr_stats
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int                 PTR_W   = (SCRUB_DEPTH > 1) ? $clog2(SCRUB_DEPTH) : 1;
  localparam int                 LVL_W   = $clog2(SCRUB_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(SCRUB_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);

  // --------------------------------------------------------------------------
  // Word classification: flags only mean something on a valid word, and a
  // double error dominates a simultaneous single-error flag.
  // --------------------------------------------------------------------------
  logic is_ue;
  logic is_ce;
  logic is_err;

  assign is_ue  = rd_valid & dec_double_err;
  assign is_ce  = rd_valid & dec_single_err & ~dec_double_err;
  assign is_err = is_ue | is_ce;

  // --------------------------------------------------------------------------
  // Read-return register: fixed one-cycle latency, payload holds when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_uncorr <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        out_data   <= dec_data;
        out_addr   <= rd_addr;
        out_uncorr <= dec_double_err;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating error counters; a clear coincident with an event restarts at 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (clr_stats) begin
        ce_count <= is_ce ? CNT_WIDTH'(1) : '0;
        ue_count <= is_ue ? CNT_WIDTH'(1) : '0;
      end else begin
        if (is_ce && (ce_count != CNT_MAX)) begin
          ce_count <= ce_count + CNT_WIDTH'(1);
        end
        if (is_ue && (ue_count != CNT_MAX)) begin
          ue_count <= ue_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // First-error log: an empty log takes any error, a CE entry may be upgraded
  // by a UE, a UE entry is final until cleared. A clear with a same-cycle
  // error leaves that error logged.
  // --------------------------------------------------------------------------
  logic log_take;

  assign log_take = is_err & (clr_stats | ~log_valid | (is_ue & ~log_is_ue));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      log_valid    <= 1'b0;
      log_is_ue    <= 1'b0;
      log_addr     <= '0;
      log_syndrome <= '0;
    end else if (log_take) begin
      log_valid    <= 1'b1;
      log_is_ue    <= is_ue;
      log_addr     <= rd_addr;
      log_syndrome <= dec_syndrome;
    end else if (clr_stats) begin
      log_valid    <= 1'b0;
      log_is_ue    <= 1'b0;
      log_addr     <= '0;
      log_syndrome <= '0;
    end
  end

  // Interrupt is a pure level view of the log contents.
  assign irq = log_valid & log_is_ue;

  // --------------------------------------------------------------------------
  // Scrub FIFO control. A pop in the same cycle frees the slot for a push
  // that arrives while full; otherwise the push is dropped and flagged.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_mem [SCRUB_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [SCRUB_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      fill_level;
  logic                  push_req;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_ok;
  logic                  push_drop;

  assign push_req    = SCRUB_EN & is_ce;
  assign fifo_full   = (fill_level == LVL_FULL);
  assign scrub_valid = (fill_level != '0);
  assign pop         = scrub_valid & scrub_ready;
  assign push_ok     = push_req & (~fifo_full | pop);
  assign push_drop   = push_req & fifo_full & ~pop;

  // Head entry is presented straight from storage.
  assign scrub_addr = addr_mem[rd_ptr];
  assign scrub_data = data_mem[rd_ptr];

  // Storage and write pointer; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < SCRUB_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push_ok) begin
      addr_mem[wr_ptr] <= rd_addr;
      data_mem[wr_ptr] <= dec_data;
      wr_ptr           <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   fill_level <= fill_level + LVL_ONE;
        2'b01:   fill_level <= fill_level - LVL_ONE;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the clearing cycle still sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scrub_ovf <= 1'b0;
    end else if (push_drop) begin
      scrub_ovf <= 1'b1;
    end else if (clr_stats) begin
      scrub_ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc_rd_err_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_rd_err_handler
//  Description : Directed self-checking bench for ecc_rd_err_handler
//                (CNT_WIDTH=4 so counter saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_rd_err_handler;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] dec_data = '0;
  logic          dec_single_err = 1'b0;
  logic          dec_double_err = 1'b0;
  logic [SW-1:0] dec_syndrome = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_uncorr;
  logic          scrub_valid;
  logic          scrub_ready = 1'b0;
  logic [AW-1:0] scrub_addr;
  logic [DW-1:0] scrub_data;
  logic          scrub_ovf;
  logic [CW-1:0] ce_count;
  logic [CW-1:0] ue_count;
  logic          log_valid;
  logic          log_is_ue;
  logic [AW-1:0] log_addr;
  logic [SW-1:0] log_syndrome;
  logic          irq;
  logic          clr_stats = 1'b0;

  int checks = 0;
  int errors = 0;

  ecc_rd_err_handler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYND_WIDTH(SW), .CNT_WIDTH(CW),
    .SCRUB_DEPTH(4), .SCRUB_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .dec_data(dec_data),
    .dec_single_err(dec_single_err), .dec_double_err(dec_double_err),
    .dec_syndrome(dec_syndrome),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_uncorr(out_uncorr),
    .scrub_valid(scrub_valid), .scrub_ready(scrub_ready),
    .scrub_addr(scrub_addr), .scrub_data(scrub_data), .scrub_ovf(scrub_ovf),
    .ce_count(ce_count), .ue_count(ue_count),
    .log_valid(log_valid), .log_is_ue(log_is_ue), .log_addr(log_addr),
    .log_syndrome(log_syndrome), .irq(irq), .clr_stats(clr_stats)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic se, input logic de, input logic [SW-1:0] s);
    rd_valid       = v;
    rd_addr        = a;
    dec_data       = d;
    dec_single_err = se;
    dec_double_err = de;
    dec_syndrome   = s;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Pulse clr_stats for one cycle with no word on the bus.
  task automatic clear_stats();
    idle();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if ({ce_count, ue_count} !== '0) begin errors++; $display("FAIL reset_counts: got %h exp 0", {ce_count, ue_count}); end
    checks++; if ({log_valid, irq, scrub_valid, scrub_ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {log_valid, irq, scrub_valid, scrub_ovf}); end
  endtask

  task automatic test_clean();
    drive(1'b1, 32'h100, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0, 8'h00);
    tick();
    idle();
    checks++; if ({out_valid, out_uncorr} !== 2'b10) begin errors++; $display("FAIL clean_valid_uncorr: got %b exp 10", {out_valid, out_uncorr}); end
    checks++; if (out_addr !== 32'h100) begin errors++; $display("FAIL clean_addr: got %h exp 100", out_addr); end
    checks++; if (out_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin errors++; $display("FAIL clean_data: got %h exp a5a5a5a5a5a5a5a5", out_data); end
    checks++; if ({ce_count, ue_count, scrub_valid, log_valid} !== '0) begin errors++; $display("FAIL clean_side_effects: got %h exp 0", {ce_count, ue_count, scrub_valid, log_valid}); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin errors++; $display("FAIL clean_hold: got valid=%b data=%h exp valid=0 data held", out_valid, out_data); end
  endtask

  task automatic test_ce();
    drive(1'b1, 32'h200, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 8'h13);
    tick();
    idle();
    checks++; if (ce_count !== 4'd1) begin errors++; $display("FAIL ce_count: got %0d exp 1", ce_count); end
    checks++; if ({log_valid, log_is_ue, irq} !== 3'b100) begin errors++; $display("FAIL ce_log_flags: got %b exp 100", {log_valid, log_is_ue, irq}); end
    checks++; if (log_addr !== 32'h200 || log_syndrome !== 8'h13) begin errors++; $display("FAIL ce_log_entry: got %h/%h exp 200/13", log_addr, log_syndrome); end
    checks++; if (scrub_valid !== 1'b1 || scrub_addr !== 32'h200) begin errors++; $display("FAIL ce_scrub_head: got %b/%h exp 1/200", scrub_valid, scrub_addr); end
    checks++; if (scrub_data !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL ce_scrub_data: got %h exp 123456789abcdef0", scrub_data); end
    scrub_ready = 1'b1;
    tick();
    scrub_ready = 1'b0;
    checks++; if (scrub_valid !== 1'b0) begin errors++; $display("FAIL ce_scrub_pop: got %b exp 0", scrub_valid); end
    // Error flags must be ignored without rd_valid.
    drive(1'b0, 32'h300, '0, 1'b1, 1'b1, 8'hFF);
    tick();
    idle();
    checks++; if ({ce_count, ue_count} !== {4'd1, 4'd0}) begin errors++; $display("FAIL ignore_invalid_flags: got %h exp 10", {ce_count, ue_count}); end
  endtask

  task automatic test_ue_log();
    clear_stats();
    checks++; if ({ce_count, log_valid} !== 5'b0) begin errors++; $display("FAIL clr_stats: got %h exp 0", {ce_count, log_valid}); end
    drive(1'b1, 32'h10, 64'h10, 1'b1, 1'b0, 8'h21);
    tick();
    drive(1'b1, 32'h20, 64'h20, 1'b1, 1'b1, 8'h42);
    tick();
    checks++; if (out_uncorr !== 1'b1) begin errors++; $display("FAIL ue_out_uncorr: got %b exp 1", out_uncorr); end
    drive(1'b1, 32'h30, 64'h30, 1'b0, 1'b1, 8'h55);
    tick();
    idle();
    checks++; if (log_addr !== 32'h20 || log_syndrome !== 8'h42) begin errors++; $display("FAIL ue_log_entry: got %h/%h exp 20/42", log_addr, log_syndrome); end
    checks++; if ({log_valid, log_is_ue, irq} !== 3'b111) begin errors++; $display("FAIL ue_log_flags: got %b exp 111", {log_valid, log_is_ue, irq}); end
    checks++; if ({ce_count, ue_count} !== {4'd1, 4'd2}) begin errors++; $display("FAIL ue_counts: got %h exp 12", {ce_count, ue_count}); end
    checks++; if (scrub_valid !== 1'b1 || scrub_addr !== 32'h10) begin errors++; $display("FAIL ue_scrub_head: got %b/%h exp 1/10", scrub_valid, scrub_addr); end
    scrub_ready = 1'b1;
    tick();
    scrub_ready = 1'b0;
    checks++; if (scrub_valid !== 1'b0) begin errors++; $display("FAIL ue_not_queued: got %b exp 0", scrub_valid); end
  endtask

  task automatic test_scrub_ovf();
    logic [AW-1:0] exp_q [4];
    clear_stats();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b exp 0", irq); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + AW'(i), 64'hC0DE_0000 + DW'(i), 1'b1, 1'b0, 8'h01);
      tick();
    end
    idle();
    checks++; if (scrub_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", scrub_ovf); end
    checks++; if (ce_count !== 4'd5) begin errors++; $display("FAIL ovf_ce_count: got %0d exp 5", ce_count); end
    clear_stats();
    checks++; if (scrub_ovf !== 1'b0 || scrub_addr !== 32'h1000) begin errors++; $display("FAIL ovf_clear_keep_fifo: got %b/%h exp 0/1000", scrub_ovf, scrub_addr); end
    // Full FIFO with a same-cycle pop accepts the push.
    scrub_ready = 1'b1;
    drive(1'b1, 32'h1005, 64'hC0DE_0005, 1'b1, 1'b0, 8'h01);
    tick();
    idle();
    checks++; if (scrub_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pop_push: got %b exp 0", scrub_ovf); end
    exp_q[0] = 32'h1001; exp_q[1] = 32'h1002; exp_q[2] = 32'h1003; exp_q[3] = 32'h1005;
    for (int i = 0; i < 4; i++) begin
      checks++; if (scrub_valid !== 1'b1 || scrub_addr !== exp_q[i]) begin errors++; $display("FAIL drain_%0d: got %b/%h exp 1/%h", i, scrub_valid, scrub_addr, exp_q[i]); end
      tick();
    end
    scrub_ready = 1'b0;
    checks++; if (scrub_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b exp 0", scrub_valid); end
  endtask

  task automatic test_saturate();
    clear_stats();
    scrub_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h4000 + AW'(i), 64'h0, 1'b1, 1'b0, 8'h07);
      tick();
    end
    idle();
    checks++; if (ce_count !== 4'd15) begin errors++; $display("FAIL ce_saturate: got %0d exp 15", ce_count); end
    checks++; if (log_addr !== 32'h4000) begin errors++; $display("FAIL ce_first_logged: got %h exp 4000", log_addr); end
    clr_stats = 1'b1;
    drive(1'b1, 32'h777, 64'h0, 1'b1, 1'b0, 8'h3C);
    tick();
    clr_stats = 1'b0;
    idle();
    checks++; if (ce_count !== 4'd1) begin errors++; $display("FAIL clr_with_ce_count: got %0d exp 1", ce_count); end
    checks++; if ({log_valid, log_is_ue} !== 2'b10 || log_addr !== 32'h777) begin errors++; $display("FAIL clr_with_ce_log: got %b/%h exp 10/777", {log_valid, log_is_ue}, log_addr); end
    tick();
    tick();
    scrub_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + AW'(i), 64'hDEAD, 1'b1, 1'b0, 8'h09);
      tick();
    end
    drive(1'b1, 32'h999, 64'hBEEF, 1'b0, 1'b1, 8'h11);
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, scrub_valid, log_valid, irq} !== 4'b0) begin errors++; $display("FAIL async_reset_flags: got %b exp 0000", {out_valid, scrub_valid, log_valid, irq}); end
    checks++; if ({scrub_addr, ce_count, out_addr} !== '0) begin errors++; $display("FAIL async_reset_values: got %h exp 0", {scrub_addr, ce_count, out_addr}); end
    tick();
    reset = 1'b0;
    idle();
    tick();
    checks++; if ({out_valid, scrub_valid, ue_count} !== '0) begin errors++; $display("FAIL post_reset: got %h exp 0", {out_valid, scrub_valid, ue_count}); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_ce();
    test_ue_log();
    test_scrub_ovf();
    test_saturate();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
